// File: rtl/irq_source_arbiter_8_pkg.sv
// Purpose : shared constants and types for the 8-source interrupt arbiter.
// Contents: source count, id width, default masks, FSM state encoding.
package irq_source_arbiter_8_pkg;

  localparam int unsigned NUM_SOURCES = 8;
  localparam int unsigned ID_W        = 3;

  localparam logic [NUM_SOURCES-1:0] DEFAULT_INVERT_MASK = 8'h00;
  localparam logic [NUM_SOURCES-1:0] DEFAULT_EDGE_MASK   = 8'hFF;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StPend    = 2'b01,
    StService = 2'b10
  } state_e;

endpackage

// File: rtl/irq_source_arbiter_8_if.sv
// Purpose : request/handshake bundle between interrupt sources, the CPU and the arbiter.
// Signals : req[8], enable[8], ack, eoi  (driven by master)
//           irq_out, irq_id[3], busy, pending[8]  (driven by the arbiter, slave side)
interface irq_source_arbiter_8_if;
  import irq_source_arbiter_8_pkg::*;

  logic [NUM_SOURCES-1:0] req;
  logic [NUM_SOURCES-1:0] enable;
  logic                   ack;
  logic                   eoi;
  logic                   irq_out;
  logic [ID_W-1:0]        irq_id;
  logic                   busy;
  logic [NUM_SOURCES-1:0] pending;

  modport master (
    output req, enable, ack, eoi,
    input  irq_out, irq_id, busy, pending
  );

  modport slave (
    input  req, enable, ack, eoi,
    output irq_out, irq_id, busy, pending
  );

endinterface

// File: rtl/irq_source_arbiter_8_prio_enc_8.sv
// Purpose : combinational priority encoder, lowest set bit wins.
// Ports   : i_vec[8]  candidate vector
//           o_idx[3]  index of the lowest set bit (0 when none set)
//           o_valid   any bit of i_vec set
module irq_source_arbiter_8_prio_enc_8
  import irq_source_arbiter_8_pkg::*;
(
  input  logic [NUM_SOURCES-1:0] i_vec,
  output logic [ID_W-1:0]        o_idx,
  output logic                   o_valid
);

  always_comb begin
    o_idx   = '0;
    o_valid = |i_vec;
    // Scan downward so the last hit written is the lowest index.
    for (int i = int'(NUM_SOURCES) - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_source_arbiter_8.sv
// Purpose : recovers which of 8 request sources fired, latches them as pending and
//           presents one registered interrupt plus the id of the lowest enabled
//           pending source, with an ack / end-of-interrupt handshake.
// Ports   : clock  system clock, rising edge
//           reset  synchronous, active-high
//           bus    slave side of irq_source_arbiter_8_if (req, enable, ack, eoi in;
//                  irq_out, irq_id, busy, pending out)
module irq_source_arbiter_8
  import irq_source_arbiter_8_pkg::*;
#(
  parameter logic [NUM_SOURCES-1:0] InvertMask = DEFAULT_INVERT_MASK,
  parameter logic [NUM_SOURCES-1:0] EdgeMask   = DEFAULT_EDGE_MASK
) (
  input  logic                   clock,
  input  logic                   reset,
  irq_source_arbiter_8_if.slave  bus
);

  logic [NUM_SOURCES-1:0] w_real_req;
  logic [NUM_SOURCES-1:0] w_rise;
  logic [NUM_SOURCES-1:0] w_event;
  logic [NUM_SOURCES-1:0] w_clr;
  logic [ID_W-1:0]        w_enc_idx;
  logic                   w_enc_valid;
  state_e                 w_state_next;
  logic [ID_W-1:0]        w_irq_id_next;

  state_e                 r_state;
  logic [NUM_SOURCES-1:0] r_req_d;
  logic [NUM_SOURCES-1:0] r_pending;
  logic [ID_W-1:0]        r_irq_id;
  logic                   r_irq_out;
  logic                   r_busy;

  assign w_real_req = bus.req ^ InvertMask;
  assign w_rise     = w_real_req & ~r_req_d;
  assign w_event    = (EdgeMask & w_rise) | (~EdgeMask & w_real_req);

  // Only the granted source is cleared, and only in the cycle ack is taken.
  always_comb begin
    w_clr = '0;
    if (r_state == StPend && bus.ack) begin
      w_clr[r_irq_id] = 1'b1;
    end
  end

  irq_source_arbiter_8_prio_enc_8 u_prio_enc (
    .i_vec   (r_pending & bus.enable),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_valid)
  );

  always_comb begin
    w_state_next  = r_state;
    w_irq_id_next = r_irq_id;
    case (r_state)
      StIdle: begin
        if (w_enc_valid) begin
          w_state_next  = StPend;
          w_irq_id_next = w_enc_idx;
        end
      end
      // ack wins over a simultaneous eoi because eoi is not looked at here.
      StPend: begin
        if (bus.ack) begin
          w_state_next = StService;
        end
      end
      StService: begin
        if (bus.eoi) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= StIdle;
      // Seed the edge history so a line already active at reset is not an edge.
      r_req_d   <= w_real_req;
      r_pending <= '0;
      r_irq_id  <= '0;
      r_irq_out <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_req_d   <= w_real_req;
      // Set beats clear so an edge coinciding with ack is kept.
      r_pending <= w_event | (r_pending & ~w_clr);
      r_irq_id  <= w_irq_id_next;
      r_irq_out <= (w_state_next == StPend);
      r_busy    <= (w_state_next == StService);
    end
  end

  assign bus.irq_out = r_irq_out;
  assign bus.irq_id  = r_irq_id;
  assign bus.busy    = r_busy;
  assign bus.pending = r_pending;

endmodule
